// File: rtl/register_writeback_scheduler_pkg.sv
// Shared constants and packed-port helpers for the register writeback scheduler.
package register_writeback_scheduler_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_DEPTH   = 5;
    localparam int unsigned DEF_NUM_REQ = 3;

    // Requester 0 is the ALU; the round-robin pointer restarts there.
    localparam int unsigned REQ_ALU = 0;

    // Low bit of field k in a packed port of w-bit fields.
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

    // Total width of a packed port carrying n fields of w bits.
    function automatic int unsigned packed_width(input int unsigned n, input int unsigned w);
        return n * w;
    endfunction

endpackage

// File: rtl/register_writeback_scheduler_if.sv
// Issue, writeback-request and register-file-write bundle of the scheduler.
// master: execute/memory side plus issue stage; slave: the scheduler.
interface register_writeback_scheduler_if
    import register_writeback_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
);
    localparam int unsigned NREG = 2 ** DEPTH;

    logic                                     issue_valid;
    logic                                     issue_rd_write;
    logic [DEPTH-1:0]                         issue_rd;
    logic                                     issue_rs1_used;
    logic                                     issue_rs2_used;
    logic [DEPTH-1:0]                         issue_rs1;
    logic [DEPTH-1:0]                         issue_rs2;
    logic                                     issue_stall;

    logic [NUM_REQ-1:0]                       req_valid;
    logic [packed_width(NUM_REQ, DEPTH)-1:0]  req_index;
    logic [packed_width(NUM_REQ, WIDTH)-1:0]  req_data;
    logic [NUM_REQ-1:0]                       req_ready;

    logic                                     rf_write_enable;
    logic [DEPTH-1:0]                         rf_write_index;
    logic [WIDTH-1:0]                         rf_write_data;
    logic [NREG-1:0]                          busy_vector;

    modport master (
        output issue_valid, issue_rd_write, issue_rd,
        output issue_rs1_used, issue_rs2_used, issue_rs1, issue_rs2,
        output req_valid, req_index, req_data,
        input  issue_stall, req_ready,
        input  rf_write_enable, rf_write_index, rf_write_data, busy_vector
    );

    modport slave (
        input  issue_valid, issue_rd_write, issue_rd,
        input  issue_rs1_used, issue_rs2_used, issue_rs1, issue_rs2,
        input  req_valid, req_index, req_data,
        output issue_stall, req_ready,
        output rf_write_enable, rf_write_index, rf_write_data, busy_vector
    );

endinterface

// File: rtl/register_writeback_scheduler_round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the
// pointer (with wrap); the pointer moves past the winner when advance is set.
// Ports: clk, reset (async active-low), request[NUM_REQ], advance,
//        grant[NUM_REQ] (combinational).
module round_robin_arbiter
    import register_writeback_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] request,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             found;
    int unsigned      cand;

    // Search from the pointer upward, wrapping past the last requester.
    always_comb begin
        grant   = '0;
        win_idx = ptr_q;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && request[PTR_W'(cand)]) begin
                found   = 1'b1;
                win_idx = PTR_W'(cand);
            end
        end
        if (found) begin
            grant[win_idx] = 1'b1;
        end
        next_ptr = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
    end

    // Pointer register; holds when no transfer happens.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= PTR_W'(REQ_ALU);
        end else if (advance && found) begin
            ptr_q <= next_ptr;
        end
    end

endmodule

// File: rtl/register_writeback_scheduler.sv
// Shares the register-file write port among NUM_REQ writeback sources,
// keeps a per-register busy scoreboard and stalls issue on RAW/WAW hazards.
// Ports: clk, reset (async active-low), bus (slave modport):
//   issue_*            issuing instruction; issue_stall combinational
//   req_valid/index/data, req_ready (combinational one-hot grant)
//   rf_write_enable/index/data registered; busy_vector scoreboard state
module register_writeback_scheduler
    import register_writeback_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic                           clk,
    input  logic                           reset,
    register_writeback_scheduler_if.slave  bus
);
    localparam int unsigned NREG = 2 ** DEPTH;

    logic [DEPTH-1:0]   req_index_a [NUM_REQ];
    logic [WIDTH-1:0]   req_data_a  [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [DEPTH-1:0]   sel_index;
    logic [WIDTH-1:0]   sel_data;

    logic               rf_we_q;
    logic [DEPTH-1:0]   rf_idx_q;
    logic [WIDTH-1:0]   rf_data_q;
    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    busy_d;
    logic               stall;
    logic               issue_fire;

    // Split packed request ports into per-source fields.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_index_a[k] = bus.req_index[slice_lo(k, DEPTH) +: DEPTH];
        assign req_data_a[k]  = bus.req_data[slice_lo(k, WIDTH) +: WIDTH];
    end

    round_robin_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .request (bus.req_valid),
        .advance (xfer),
        .grant   (grant)
    );

    assign xfer = |(bus.req_valid & grant);

    // One-hot mux of the granted source's index and data.
    always_comb begin
        sel_index = '0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_index = sel_index | req_index_a[k];
                sel_data  = sel_data  | req_data_a[k];
            end
        end
    end

    // Hazard check reads the registered scoreboard, so a register stays
    // blocked through its write cycle and frees up the cycle after.
    assign stall = bus.issue_valid &
                   ((bus.issue_rs1_used & busy_q[bus.issue_rs1]) |
                    (bus.issue_rs2_used & busy_q[bus.issue_rs2]) |
                    (bus.issue_rd_write & busy_q[bus.issue_rd]));
    assign issue_fire = bus.issue_valid & ~stall;

    // Scoreboard update: clear on write-back, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_idx_q] = 1'b0;
        end
        if (issue_fire && bus.issue_rd_write && (bus.issue_rd != '0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Writeback stage; x0 transfers are acknowledged but never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q   <= DISABLE;
            rf_idx_q  <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            rf_we_q <= DISABLE;
            if (xfer && (sel_index != '0)) begin
                rf_we_q   <= ENABLE;
                rf_idx_q  <= sel_index;
                rf_data_q <= sel_data;
            end
        end
    end

    assign bus.issue_stall     = stall;
    assign bus.req_ready       = grant;
    assign bus.rf_write_enable = rf_we_q;
    assign bus.rf_write_index  = rf_idx_q;
    assign bus.rf_write_data   = rf_data_q;
    assign bus.busy_vector     = busy_q;

endmodule

// File: tb/tb_register_writeback_scheduler.sv
// Bench for register_writeback_scheduler: arbitration table, hand-written
// hazard/reset sequences and a randomized run against a behavioural model.
module tb_register_writeback_scheduler;
    import register_writeback_scheduler_pkg::*;

    localparam int W = 32;
    localparam int D = 5;
    localparam int N = 3;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    register_writeback_scheduler_if #(.WIDTH(W), .DEPTH(D), .NUM_REQ(N)) bus ();

    register_writeback_scheduler #(.WIDTH(W), .DEPTH(D), .NUM_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
    } arb_vec_t;

    arb_vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_issue();
        bus.issue_valid    = 1'b0;
        bus.issue_rd_write = 1'b0;
        bus.issue_rd       = '0;
        bus.issue_rs1_used = 1'b0;
        bus.issue_rs2_used = 1'b0;
        bus.issue_rs1      = '0;
        bus.issue_rs2      = '0;
    endtask

    task automatic idle_req();
        bus.req_valid = '0;
        bus.req_index = '0;
        bus.req_data  = '0;
    endtask

    task automatic set_req(input int k, input logic [D-1:0] idx, input logic [W-1:0] data);
        bus.req_index[k*D +: D] = idx;
        bus.req_data[k*W +: W]  = data;
    endtask

    task automatic issue_wr(input logic [D-1:0] rd);
        idle_issue();
        bus.issue_valid    = 1'b1;
        bus.issue_rd_write = 1'b1;
        bus.issue_rd       = rd;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Behavioural model state for the randomized run
    int              m_ptr;
    logic [31:0]     m_busy;
    logic            m_we;
    logic [D-1:0]    m_idx;
    logic [W-1:0]    m_data;
    logic            act   [N];
    logic [D-1:0]    r_idx [N];
    logic [W-1:0]    r_data[N];

    initial begin
        logic          prev_we;
        logic [D-1:0]  prev_idx;
        logic [W-1:0]  prev_data;
        int            win;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle_issue();
        idle_req();

        tbl[0]  = '{3'b111, 3'b001};
        tbl[1]  = '{3'b111, 3'b010};
        tbl[2]  = '{3'b111, 3'b100};
        tbl[3]  = '{3'b111, 3'b001};
        tbl[4]  = '{3'b111, 3'b010};
        tbl[5]  = '{3'b111, 3'b100};
        tbl[6]  = '{3'b001, 3'b001};
        tbl[7]  = '{3'b101, 3'b100};
        tbl[8]  = '{3'b110, 3'b010};
        tbl[9]  = '{3'b011, 3'b001};
        tbl[10] = '{3'b000, 3'b000};
        tbl[11] = '{3'b100, 3'b100};

        // Reset values
        tick();
        tick();
        smp();
        chk("reset_busy", bus.busy_vector, 32'h0);
        chk("reset_we", 32'(bus.rf_write_enable), 32'h0);
        chk("reset_idx", 32'(bus.rf_write_index), 32'h0);
        chk("reset_data", bus.rf_write_data, 32'h0);
        tick();
        reset = 1'b1;

        // Arbitration table: each source k writes x(10+k) with a fixed payload
        prev_we   = 1'b0;
        prev_idx  = '0;
        prev_data = '0;
        for (int k = 0; k < N; k++) set_req(k, D'(10 + k), 32'hA0A0_0000 | 32'(k));
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = tbl[i].valid;
            smp();
            chk($sformatf("tbl%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_we", i), 32'(bus.rf_write_enable), 32'(prev_we));
            if (prev_we) begin
                chk($sformatf("tbl%0d_idx", i), 32'(bus.rf_write_index), 32'(prev_idx));
                chk($sformatf("tbl%0d_data", i), bus.rf_write_data, prev_data);
            end
            win     = onehot_idx(tbl[i].exp_ready);
            prev_we = (win >= 0);
            if (win >= 0) begin
                prev_idx  = D'(10 + win);
                prev_data = 32'hA0A0_0000 | 32'(win);
            end
            tick();
        end
        idle_req();
        smp();
        chk("tbl_last_we", 32'(bus.rf_write_enable), 32'(prev_we));
        tick();

        // Reset in the middle of a write to x7
        issue_wr(5'd7);
        smp();
        chk("rst7_issue_stall", 32'(bus.issue_stall), 32'h0);
        tick();
        idle_issue();
        bus.req_valid = 3'b001;
        set_req(REQ_ALU, 5'd7, 32'h7777_0007);
        smp();
        chk("rst7_ready", 32'(bus.req_ready), 32'h1);
        chk("rst7_busy", bus.busy_vector, 32'h80);
        tick();
        idle_req();
        chk("rst7_we_before", 32'(bus.rf_write_enable), 32'h1);
        reset = 1'b0;
        #1;
        chk("rst7_we_async", 32'(bus.rf_write_enable), 32'h0);
        chk("rst7_busy_async", bus.busy_vector, 32'h0);
        tick();
        chk("rst7_we_held", 32'(bus.rf_write_enable), 32'h0);
        reset = 1'b1;
        bus.req_valid = 3'b111;
        for (int k = 0; k < N; k++) set_req(k, D'(10 + k), 32'hB0B0_0000 | 32'(k));
        smp();
        chk("rst_ptr_ready", 32'(bus.req_ready), 32'h1);
        tick();
        idle_req();

        // RAW on x5 released two cycles after the grant
        issue_wr(5'd5);
        smp();
        chk("raw5_fire", 32'(bus.issue_stall), 32'h0);
        tick();
        idle_issue();
        bus.issue_valid    = 1'b1;
        bus.issue_rs1_used = 1'b1;
        bus.issue_rs1      = 5'd5;
        smp();
        chk("raw5_stall", 32'(bus.issue_stall), 32'h1);
        tick();
        bus.req_valid = 3'b010;
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        smp();
        chk("raw5_ready_n", 32'(bus.req_ready), 32'h2);
        chk("raw5_stall_n", 32'(bus.issue_stall), 32'h1);
        tick();
        idle_req();
        smp();
        chk("raw5_we_n1", 32'(bus.rf_write_enable), 32'h1);
        chk("raw5_idx_n1", 32'(bus.rf_write_index), 32'h5);
        chk("raw5_data_n1", bus.rf_write_data, 32'hDEAD_BEEF);
        chk("raw5_stall_n1", 32'(bus.issue_stall), 32'h1);
        tick();
        smp();
        chk("raw5_stall_n2", 32'(bus.issue_stall), 32'h0);
        chk("raw5_busy_n2", bus.busy_vector, 32'h0);
        chk("raw5_we_n2", 32'(bus.rf_write_enable), 32'h0);
        tick();
        idle_issue();

        // x0 write is acked but never committed
        issue_wr(5'd20);
        smp();
        tick();
        idle_issue();
        bus.req_valid = 3'b100;
        set_req(2, 5'd0, 32'h0000_1234);
        smp();
        chk("x0_ready", 32'(bus.req_ready), 32'h4);
        tick();
        idle_req();
        smp();
        chk("x0_we", 32'(bus.rf_write_enable), 32'h0);
        chk("x0_busy", bus.busy_vector, 32'h0010_0000);
        tick();
        bus.req_valid = 3'b001;
        set_req(0, 5'd20, 32'h2020_2020);
        tick();
        idle_req();
        tick();
        smp();
        chk("x20_cleared", bus.busy_vector, 32'h0);
        tick();

        // Issue reserving x9 on the same edge that x9 is written: set wins
        bus.req_valid = 3'b001;
        set_req(0, 5'd9, 32'h9999_9999);
        smp();
        chk("x9_ready", 32'(bus.req_ready), 32'h1);
        tick();
        idle_req();
        issue_wr(5'd9);
        smp();
        chk("x9_we", 32'(bus.rf_write_enable), 32'h1);
        chk("x9_idx", 32'(bus.rf_write_index), 32'h9);
        chk("x9_fire", 32'(bus.issue_stall), 32'h0);
        tick();
        idle_issue();
        smp();
        chk("x9_busy", bus.busy_vector, 32'h200);
        tick();
        bus.req_valid = 3'b001;
        set_req(0, 5'd9, 32'h0909_0909);
        tick();
        idle_req();
        tick();
        smp();
        chk("x9_cleared", bus.busy_vector, 32'h0);
        tick();

        // WAW on x3; unused rs1 does not stall
        issue_wr(5'd3);
        smp();
        chk("waw3_first_fire", 32'(bus.issue_stall), 32'h0);
        tick();
        issue_wr(5'd3);
        smp();
        chk("waw3_stall", 32'(bus.issue_stall), 32'h1);
        idle_issue();
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = 5'd3;
        #1;
        chk("waw3_rs1_unused", 32'(bus.issue_stall), 32'h0);
        issue_wr(5'd3);
        tick();
        bus.req_valid = 3'b100;
        set_req(2, 5'd3, 32'h3333_3333);
        smp();
        chk("waw3_ready_n", 32'(bus.req_ready), 32'h4);
        chk("waw3_stall_n", 32'(bus.issue_stall), 32'h1);
        tick();
        idle_req();
        smp();
        chk("waw3_we_n1", 32'(bus.rf_write_enable), 32'h1);
        chk("waw3_stall_n1", 32'(bus.issue_stall), 32'h1);
        tick();
        smp();
        chk("waw3_stall_n2", 32'(bus.issue_stall), 32'h0);
        tick();
        idle_issue();
        smp();
        chk("waw3_rebusy", bus.busy_vector, 32'h8);
        tick();

        // Randomized run against the behavioural model
        reset = 1'b0;
        idle_issue();
        idle_req();
        tick();
        tick();
        reset = 1'b1;
        m_ptr  = 0;
        m_busy = '0;
        m_we   = 1'b0;
        m_idx  = '0;
        m_data = '0;
        for (int k = 0; k < N; k++) begin
            act[k]    = 1'b0;
            r_idx[k]  = '0;
            r_data[k] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic         iv, rw, u1, u2;
            logic [D-1:0] rd, rs1, rs2;
            logic         exp_stall;
            logic [N-1:0] exp_ready;
            logic [31:0]  nb;
            int           winner;

            for (int k = 0; k < N; k++) begin
                if (!act[k] && ($urandom_range(0, 2) != 0)) begin
                    int start;
                    logic picked;
                    act[k]    = 1'b1;
                    r_data[k] = $urandom;
                    r_idx[k]  = D'($urandom_range(0, 31));
                    picked    = 1'b0;
                    start     = int'($urandom_range(0, 31));
                    if ($urandom_range(0, 3) != 0) begin
                        for (int j = 0; j < 32; j++) begin
                            if (!picked && m_busy[(start + j) % 32]) begin
                                picked   = 1'b1;
                                r_idx[k] = D'((start + j) % 32);
                            end
                        end
                    end
                end
                bus.req_valid[k] = act[k];
                set_req(k, r_idx[k], r_data[k]);
            end
            iv  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            rd  = D'($urandom_range(0, 31));
            rs1 = D'($urandom_range(0, 31));
            rs2 = D'($urandom_range(0, 31));
            bus.issue_valid    = iv;
            bus.issue_rd_write = rw;
            bus.issue_rd       = rd;
            bus.issue_rs1_used = u1;
            bus.issue_rs2_used = u2;
            bus.issue_rs1      = rs1;
            bus.issue_rs2      = rs2;

            exp_stall = iv && ((u1 && m_busy[rs1]) || (u2 && m_busy[rs2]) || (rw && m_busy[rd]));
            winner = -1;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (winner < 0 && act[k]) winner = k;
            end
            exp_ready = '0;
            if (winner >= 0) exp_ready[winner] = 1'b1;

            smp();
            chk("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rnd_stall", 32'(bus.issue_stall), 32'(exp_stall));
            chk("rnd_we", 32'(bus.rf_write_enable), 32'(m_we));
            chk("rnd_busy", bus.busy_vector, m_busy);
            if (m_we) begin
                chk("rnd_idx", 32'(bus.rf_write_index), 32'(m_idx));
                chk("rnd_data", bus.rf_write_data, m_data);
            end

            nb = m_busy;
            if (m_we) nb[m_idx] = 1'b0;
            if (iv && !exp_stall && rw && (rd != 0)) nb[rd] = 1'b1;
            m_busy = nb;
            m_we   = 1'b0;
            if (winner >= 0) begin
                m_ptr = (winner + 1) % N;
                if (r_idx[winner] != 0) begin
                    m_we   = 1'b1;
                    m_idx  = r_idx[winner];
                    m_data = r_data[winner];
                end
                act[winner] = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_writeback_scheduler.md
Name: register_writeback_scheduler

Overview:
- Shares the single write port of the 32x32 register file between NUM_REQ writeback sources (ALU, load unit, multi-cycle mul/div) using round-robin arbitration.
- Keeps a per-register busy scoreboard for destinations that have been issued but not yet written back.
- Drives a stall to the issue stage on RAW/WAW hazards.
- Sits between the execute/memory units and the register file write port.

Parameters:
- WIDTH, 32, data width of a register.
- DEPTH, 5, register index width; the file holds 2**DEPTH registers.
- NUM_REQ, 3, number of writeback requesters. Requester 0 is the ALU.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- issue_valid  input  1  instruction present at issue.
- issue_rd_write  input  1  issuing instruction writes a destination.
- issue_rd  input  DEPTH  destination index.
- issue_rs1_used, issue_rs2_used  input  1 each  source operand is read.
- issue_rs1, issue_rs2  input  DEPTH each  source indices.
- issue_stall  output  1  hold issue this cycle (combinational).
- req_valid  input  NUM_REQ  writeback request per source.
- req_index  input  NUM_REQ*DEPTH  packed destination indices; source k uses bits [k*DEPTH +: DEPTH].
- req_data  input  NUM_REQ*WIDTH  packed write data.
- req_ready  output  NUM_REQ  one-hot grant (combinational).
- rf_write_enable  output  1  to register file write_enable (registered).
- rf_write_index  output  DEPTH  registered.
- rf_write_data  output  WIDTH  registered.
- busy_vector  output  2**DEPTH  scoreboard state; bit 0 is always 0.

Behaviour:
- Reset (reset=0, async):
  - busy_vector=0, rf_write_enable=0, rf_write_index=0, rf_write_data=0.
  - Round-robin pointer=0.
  - Takes effect mid-transfer; any in-flight grant is discarded.
- Arbitration:
  - Each cycle, grant the first requester with req_valid=1, searching from the pointer upward with wrap-around.
  - req_ready has at most one bit high, and only for a valid requester.
  - A transfer happens when req_valid[k] & req_ready[k].
  - The requester holds valid, index and data stable until it sees ready.
  - After a transfer by k, the pointer becomes (k+1) mod NUM_REQ. With no transfer, the pointer holds.
- Write latency:
  - A transfer in cycle N gives rf_write_enable=1 with the captured index and data in cycle N+1.
  - The register file commits at the end of N+1.
  - With no transfer, rf_write_enable=0 and index/data hold their last values.
- x0 rule:
  - A transfer with index 0 is acknowledged normally (ready=1).
  - It produces rf_write_enable=0 in N+1.
- Scoreboard:
  - Issue fire = issue_valid & ~issue_stall.
  - Fire with issue_rd_write & issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - A cycle with rf_write_enable=1 clears busy[rf_write_index] at that edge.
  - Set and clear of the same index on one edge: set wins.
  - Clearing a non-busy index is harmless.
  - busy[0] is never set.
- Stall (combinational), issue_stall = issue_valid & (A | B | C):
  - A: issue_rs1_used & busy[issue_rs1]
  - B: issue_rs2_used & busy[issue_rs2]
  - C: issue_rd_write & busy[issue_rd] (WAW; at most one outstanding write per register)
- The stall is not released in the cycle rf_write_enable is high. It releases the cycle after, when the register file read returns new data. No bypassing.
- A requester writing a register that is not busy is legal; the RF is simply written.

Decomposition:
- Shared defines file additions: ENABLE/DISABLE are already present. Add a REQ_ALU=0 constant and the packed-port slice width helpers.
- One sub-module, round_robin_arbiter:
  - Parameter NUM_REQ.
  - Inputs clk, reset, request vector, advance.
  - Output one-hot grant.
  - Owns the pointer register.
- The scheduler instantiates it and holds the scoreboard and writeback registers.

Test Plan:
- Reset mid-write: req_valid=001, index 7 granted; assert reset in the following cycle → rf_write_enable=0 and busy_vector=0 immediately, with no write to x7.
- Issue rd=5 (fires, busy[5]=1), then issue rs1=5 → issue_stall=1. Requester 1 writes x5=0xDEADBEEF:
  - ready in cycle N;
  - rf_write_enable in N+1;
  - stall still 1 in N+1;
  - stall 0 in N+2.
- req_valid=111 held for 6 cycles → grants 001,010,100,001,010,100. Then valid=101 from pointer=1 → grant 100.
- Write to x0 from requester 2 with data 0x1234 → req_ready[2]=1, rf_write_enable=0 next cycle, busy_vector unchanged.
- Issue rd=9 fires in the same cycle as rf_write_enable=1 with index 9 (prior reservation) → busy[9]=1 after the edge.
- WAW: busy[3]=1, issue rd=3 with no sources → issue_stall=1 until cycle after x3 writeback; rs1=3 with issue_rs1_used=0 alone → no stall.
